// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: word RAM behind a request/ready handshake
// with a programmable read latency and misaligned-address reporting.
module mem_bus_responder #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        align_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_COMMIT,
    RESP
  } state_e;

  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                mis_q, mis_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   idx_in;

  logic [31:0] mem [DEPTH];

  // Upper address bits are dropped here, so addresses alias by design.
  assign idx_in = addr[ADDR_W+1:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = idx_in;
          mis_d   = |addr[1:0];
          wdata_d = wdata;
          if (|addr[1:0]) begin
            state_d = RESP;
          end else if (wr) begin
            state_d = WR_COMMIT;
          end else if (READ_LAT <= 1) begin
            rdata_d = mem[idx_in];
            state_d = RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Leave on the edge where the count reaches zero.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          rdata_d = mem[idx_q];
          state_d = RESP;
        end
      end
      WR_COMMIT: begin
        mem_we  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata     = rdata_q;
  assign ready     = (state_q == RESP);
  assign busy      = (state_q == RD_WAIT) || (state_q == WR_COMMIT);
  assign align_err = (state_q == RESP) && mis_q;

endmodule
